ht_bank_dispatch: RTL and testbench

Front-end for a banked hash table built from NUM_BANKS independent hash-table pipelines (hash, head table, data table). Runs the post-reset RAM clear of every bank automatically and steers each command to a bank chosen from key bits. Merges per-bank results back into one stream in original command order, so banks are invisible to the user.

---
 rtl/ht_bank_dispatch.sv | 116 +++++++++++
 tb/tb_ht_bank_dispatch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ht_bank_dispatch.sv
// ht_bank_dispatch: runs the bank RAM clear, steers commands to banks by key bits, and merges results back in issue order
module ht_bank_dispatch #(
  parameter int NUM_BANKS    = 4,
  parameter int KEY_W        = 32,
  parameter int VALUE_W      = 16,
  parameter int RES_W        = 24,
  parameter int BANK_SEL_LSB = 0,
  parameter int ORDER_DEPTH  = 16,
  localparam int BW = $clog2(NUM_BANKS),
  localparam int AW = $clog2(ORDER_DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [1:0]                   cmd_opcode_i,
  input  logic [KEY_W-1:0]             cmd_key_i,
  input  logic [VALUE_W-1:0]           cmd_value_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  output logic [NUM_BANKS*2-1:0]       bank_cmd_opcode_o,
  output logic [NUM_BANKS*KEY_W-1:0]   bank_cmd_key_o,
  output logic [NUM_BANKS*VALUE_W-1:0] bank_cmd_value_o,
  output logic [NUM_BANKS-1:0]         bank_cmd_valid_o,
  input  logic [NUM_BANKS-1:0]         bank_cmd_ready_i,
  input  logic [NUM_BANKS*RES_W-1:0]   bank_res_i,
  input  logic [NUM_BANKS-1:0]         bank_res_valid_i,
  output logic [NUM_BANKS-1:0]         bank_res_ready_o,
  output logic [RES_W-1:0]             res_o,
  output logic [BW-1:0]                res_bank_o,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic                         clear_ram_run_o,
  input  logic [NUM_BANKS-1:0]         clear_ram_done_i,
  output logic                         init_done_o,
  output logic [AW:0]                  outstanding_o
);
  typedef enum logic [1:0] {CLR_START, CLR_WAIT, RUN} state_e;
  state_e state_q, state_d;
  logic [NUM_BANKS-1:0] flags_q, flags_d, bv_q, bv_d;
  logic run_q, run_d;
  logic [1:0] op_q [NUM_BANKS];
  logic [1:0] op_d [NUM_BANKS];
  logic [KEY_W-1:0] key_q [NUM_BANKS];
  logic [KEY_W-1:0] key_d [NUM_BANKS];
  logic [VALUE_W-1:0] val_q [NUM_BANKS];
  logic [VALUE_W-1:0] val_d [NUM_BANKS];
  logic [BW-1:0] order_mem [ORDER_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [RES_W-1:0] res_arr [NUM_BANKS];
  logic [BW-1:0] b, h;
  logic full, empty, push, pop;
  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    assign bank_cmd_opcode_o[i*2 +: 2]          = op_q[i];
    assign bank_cmd_key_o[i*KEY_W +: KEY_W]     = key_q[i];
    assign bank_cmd_value_o[i*VALUE_W +: VALUE_W] = val_q[i];
    assign res_arr[i]                           = bank_res_i[i*RES_W +: RES_W];
    assign bank_res_ready_o[i]                  = !empty && h == BW'(i) && res_ready_i;
  end
  always_comb begin
    b = cmd_key_i[BANK_SEL_LSB +: BW];
    h = order_mem[rd_q];
    full = cnt_q == (AW+1)'(ORDER_DEPTH);
    empty = cnt_q == '0;
    cmd_ready_o = state_q == RUN && !full && (!bv_q[b] || bank_cmd_ready_i[b]);
    push = cmd_valid_i && cmd_ready_o;
    res_valid_o = !empty && bank_res_valid_i[h];
    res_o = res_arr[h];
    res_bank_o = h;
    pop = res_valid_o && res_ready_i;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    // a handshake empties the register unless the same cycle reloads it
    bv_d = (bv_q & ~bank_cmd_ready_i) | (push ? NUM_BANKS'(1) << b : '0);
    op_d = op_q;
    key_d = key_q;
    val_d = val_q;
    if (push) begin
      op_d[b] = cmd_opcode_i;
      key_d[b] = cmd_key_i;
      val_d[b] = cmd_value_i;
    end
    flags_d = state_q == CLR_START ? '0 : state_q == CLR_WAIT ? flags_q | clear_ram_done_i : flags_q;
    state_d = state_q == CLR_START ? CLR_WAIT : (state_q == CLR_WAIT && &flags_d) ? RUN : state_q;
    run_d = state_q == CLR_START;
    bank_cmd_valid_o = bv_q;
    clear_ram_run_o = run_q;
    init_done_o = state_q == RUN;
    outstanding_o = cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLR_START;
      flags_q <= '0;
      run_q <= 1'b0;
      bv_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      run_q <= run_d;
      bv_q <= bv_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    op_q <= op_d;
    key_q <= key_d;
    val_q <= val_d;
    if (push) order_mem[wr_q] <= b;
  end
endmodule

// File: tb/tb_ht_bank_dispatch.sv
// tb_ht_bank_dispatch: directed and random checks of ht_bank_dispatch with behavioural bank models and an issue-order scoreboard
module tb_ht_bank_dispatch;
  localparam int NB = 4, KW = 32, VW = 16, RW = 24;
  logic clk_i = 1'b0;
  logic rst_i;
  logic [1:0] cmd_opcode_i;
  logic [KW-1:0] cmd_key_i;
  logic [VW-1:0] cmd_value_i;
  logic cmd_valid_i;
  logic cmd_ready_o;
  logic [NB*2-1:0] bank_cmd_opcode_o;
  logic [NB*KW-1:0] bank_cmd_key_o;
  logic [NB*VW-1:0] bank_cmd_value_o;
  logic [NB-1:0] bank_cmd_valid_o;
  logic [NB-1:0] bank_cmd_ready_i;
  logic [NB*RW-1:0] bank_res_i;
  logic [NB-1:0] bank_res_valid_i;
  logic [NB-1:0] bank_res_ready_o;
  logic [RW-1:0] res_o;
  logic [1:0] res_bank_o;
  logic res_valid_o;
  logic res_ready_i;
  logic clear_ram_run_o;
  logic [NB-1:0] clear_ram_done_i;
  logic init_done_o;
  logic [4:0] outstanding_o;

  ht_bank_dispatch dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_opcode_i(cmd_opcode_i), .cmd_key_i(cmd_key_i), .cmd_value_i(cmd_value_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .bank_cmd_opcode_o(bank_cmd_opcode_o), .bank_cmd_key_o(bank_cmd_key_o),
    .bank_cmd_value_o(bank_cmd_value_o), .bank_cmd_valid_o(bank_cmd_valid_o),
    .bank_cmd_ready_i(bank_cmd_ready_i), .bank_res_i(bank_res_i),
    .bank_res_valid_i(bank_res_valid_i), .bank_res_ready_o(bank_res_ready_o),
    .res_o(res_o), .res_bank_o(res_bank_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .clear_ram_run_o(clear_ram_run_o), .clear_ram_done_i(clear_ram_done_i),
    .init_done_o(init_done_o), .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0, n_fail = 0;
  logic [RW+1:0] exp_q [$];
  logic [RW-1:0] bq [NB][$];
  logic [NB-1:0] rdy_mask = '1, hold = '1;
  bit rand_en = 0, acc = 0;
  logic [15:0] seq = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // bank models: accept when ready, return results FIFO-per-bank unless held or stalled
  task automatic drive_banks();
    for (int i = 0; i < NB; i++) begin
      bank_cmd_ready_i[i] = rdy_mask[i] && (!rand_en || $urandom_range(3) != 0);
      bank_res_valid_i[i] = !hold[i] && bq[i].size() > 0 && (!rand_en || $urandom_range(3) != 0);
      bank_res_i[i*RW +: RW] = bq[i].size() > 0 ? bq[i][0] : '0;
    end
    if (rand_en) res_ready_i = $urandom_range(3) != 0;
  endtask

  task automatic tick();
    logic [RW+1:0] e;
    #2;
    acc = cmd_valid_i && cmd_ready_o;
    if (acc) begin
      exp_q.push_back({cmd_key_i[1:0], cmd_opcode_i, cmd_key_i[5:0], cmd_value_i});
      seq++;
    end
    for (int i = 0; i < NB; i++) begin
      if (bank_cmd_valid_o[i] && bank_cmd_ready_i[i])
        bq[i].push_back({bank_cmd_opcode_o[i*2 +: 2], bank_cmd_key_o[i*KW +: 6], bank_cmd_value_o[i*VW +: VW]});
      if (bank_res_valid_i[i] && bank_res_ready_o[i] && bq[i].size() > 0) void'(bq[i].pop_front());
    end
    if (res_valid_o && res_ready_i) begin
      chk("res_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("res_order", 64'({res_bank_o, res_o}), 64'(e));
      end
    end
    @(posedge clk_i);
    #1;
    drive_banks();
  endtask

  task automatic issue(input logic [31:0] k);
    cmd_valid_i = 1'b1;
    cmd_key_i = k;
    cmd_opcode_i = 2'($urandom_range(3));
    cmd_value_i = seq;
    for (int t = 0; t < 2000; t++) begin
      tick();
      if (acc) break;
    end
    chk("issue_accepted", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 2000; t++) begin
      if (outstanding_o == 0 && exp_q.size() == 0) break;
      tick();
    end
    chk("drain_outstanding", 64'(outstanding_o), 64'd0);
    chk("drain_scoreboard", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_key_i = '0;
    cmd_opcode_i = '0;
    cmd_value_i = '0;
    res_ready_i = 1'b1;
    clear_ram_done_i = '0;
    drive_banks();
    tick();
    tick();
    chk("rst_clear_run", 64'(clear_ram_run_o), 64'd0);
    chk("rst_init_done", 64'(init_done_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("rst_bank_valid", 64'(bank_cmd_valid_o), 64'd0);
    chk("rst_bank_res_ready", 64'(bank_res_ready_o), 64'd0);
    chk("rst_res_valid", 64'(res_valid_o), 64'd0);
    rst_i = 1'b0;
    for (int c = 0; c < 15; c++) begin
      clear_ram_done_i = c == 5 ? 4'b0001 : c == 7 ? 4'b1100 : c == 12 ? 4'b0010 : 4'b0000;
      chk("clr_run", 64'(clear_ram_run_o), 64'(c == 1));
      chk("clr_init_done", 64'(init_done_o), 64'(c >= 13));
      chk("clr_cmd_ready", 64'(cmd_ready_o), 64'(c >= 13));
      tick();
    end
    clear_ram_done_i = '0;

    for (int k = 0; k < 4; k++) begin
      cmd_valid_i = 1'b1;
      cmd_key_i = 32'h10 + 32'(k);
      cmd_opcode_i = 2'(k);
      cmd_value_i = seq;
      #1;
      chk("b2b_ready", 64'(cmd_ready_o), 64'd1);
      tick();
      chk("b2b_bank_valid", 64'(bank_cmd_valid_o), 64'd1 << k);
    end
    cmd_valid_i = 1'b0;
    chk("b2b_outstanding", 64'(outstanding_o), 64'd4);
    tick();
    for (int k = 3; k > 0; k--) begin
      hold[k] = 1'b0;
      drive_banks();
      #1;
      chk("hold_head_wait", 64'(res_valid_o), 64'd0);
      tick();
    end
    hold[0] = 1'b0;
    drive_banks();
    #1;
    chk("head_valid", 64'(res_valid_o), 64'd1);
    chk("head_bank", 64'(res_bank_o), 64'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("merge_outstanding", 64'(outstanding_o), 64'd0);

    hold = '0;
    rdy_mask = 4'b1101;
    drive_banks();
    issue(32'h01);
    cmd_key_i = 32'h05;
    cmd_value_i = seq;
    #1;
    chk("stall_ready", 64'(cmd_ready_o), 64'd0);
    tick();
    chk("stall_no_accept", 64'(acc), 64'd0);
    cmd_key_i = 32'h02;
    #1;
    chk("other_bank_ready", 64'(cmd_ready_o), 64'd1);
    tick();
    chk("other_bank_accept", 64'(acc), 64'd1);
    cmd_valid_i = 1'b0;
    rdy_mask = '1;
    drive_banks();
    issue(32'h05);
    cmd_valid_i = 1'b0;
    drain();

    hold = '1;
    drive_banks();
    for (int k = 0; k < 16; k++) issue(32'(k));
    cmd_key_i = 32'h20;
    cmd_value_i = seq;
    #1;
    chk("full_outstanding", 64'(outstanding_o), 64'd16);
    chk("full_ready", 64'(cmd_ready_o), 64'd0);
    hold[0] = 1'b0;
    drive_banks();
    #1;
    chk("full_pop_valid", 64'(res_valid_o), 64'd1);
    chk("full_pop_ready", 64'(cmd_ready_o), 64'd0);
    tick();
    chk("full_push_blocked", 64'(acc), 64'd0);
    hold = '1;
    drive_banks();
    #1;
    chk("after_pop_outstanding", 64'(outstanding_o), 64'd15);
    chk("after_pop_ready", 64'(cmd_ready_o), 64'd1);
    tick();
    chk("after_pop_accept", 64'(acc), 64'd1);
    chk("refill_outstanding", 64'(outstanding_o), 64'd16);
    cmd_valid_i = 1'b0;
    hold = '0;
    drive_banks();
    drain();

    rand_en = 1;
    for (int n = 0; n < 10000; n++) issue($urandom);
    cmd_valid_i = 1'b0;
    rand_en = 0;
    res_ready_i = 1'b1;
    drive_banks();
    drain();

    hold = '1;
    drive_banks();
    issue(32'h0);
    cmd_valid_i = 1'b0;
    tick();
    rdy_mask = '0;
    drive_banks();
    for (int k = 0; k < 4; k++) issue(32'(k));
    cmd_valid_i = 1'b0;
    #1;
    chk("pre_rst_outstanding", 64'(outstanding_o), 64'd5);
    chk("pre_rst_bank_valid", 64'(bank_cmd_valid_o), 64'hF);
    rst_i = 1'b1;
    tick();
    chk("rst2_bank_valid", 64'(bank_cmd_valid_o), 64'd0);
    chk("rst2_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst2_init_done", 64'(init_done_o), 64'd0);
    chk("rst2_cmd_ready", 64'(cmd_ready_o), 64'd0);
    exp_q.delete();
    for (int i = 0; i < NB; i++) bq[i].delete();
    rst_i = 1'b0;
    rdy_mask = '1;
    drive_banks();
    chk("rst2_run_c0", 64'(clear_ram_run_o), 64'd0);
    tick();
    chk("rst2_run_c1", 64'(clear_ram_run_o), 64'd1);
    clear_ram_done_i = '1;
    tick();
    clear_ram_done_i = '0;
    chk("rst2_run_c2", 64'(clear_ram_run_o), 64'd0);
    chk("rst2_init_done_up", 64'(init_done_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
